alu_rr_scheduler: RTL

Shares one combinational ALU among NREQ requesters. Each requester issues an operation (A, B, OP); the block picks one by round-robin, registers its operands, drives the ALU and captures Z/OV. It then returns the result on a single tagged response channel with backpressure. The ALU is instantiated beside this block; this block only sequences it.

---
 rtl/alu_rr_scheduler_if.sv | 28 ++
 rtl/alu_rr_scheduler.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler_if.sv
// Request/response channels between NREQ requesters and the shared-ALU scheduler.
// Requesters drive valid + packed operands; the scheduler returns one tagged response.
interface alu_rr_scheduler_if #(
  parameter int nIO  = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*nIO-1:0] req_a;
  logic [NREQ*nIO-1:0] req_b;
  logic [NREQ*3-1:0]   req_op;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [nIO-1:0]      rsp_z;
  logic                rsp_ov;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_z, rsp_ov
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_z, rsp_ov
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin arbiter sequencing one external ALU: grant -> EXEC -> RESP, rsp_valid 2 clocks after grant.
// Response is held stable until rsp_ready; req_ready stays low while an operation is in flight.
module alu_rr_scheduler #(
  parameter int nIO  = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_rr_scheduler_if.slave bus,
  output logic [nIO-1:0]    alu_a,
  output logic [nIO-1:0]    alu_b,
  output logic [2:0]        alu_op,
  input  logic [nIO-1:0]    alu_z,
  input  logic              alu_ov,
  output logic              busy,
  output logic [CNTW-1:0]   op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [nIO-1:0]  alu_a_q, alu_a_d;
  logic [nIO-1:0]  alu_b_q, alu_b_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [nIO-1:0]  rsp_z_q, rsp_z_d;
  logic            rsp_ov_q, rsp_ov_d;
  logic [CNTW-1:0] op_count_q, op_count_d;

  logic [nIO-1:0]  a_arr  [NREQ];
  logic [nIO-1:0]  b_arr  [NREQ];
  logic [2:0]      op_arr [NREQ];

  logic            gnt_vld;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW:0]    cand;
  logic            grant_fire;
  logic            rsp_fire;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i]  = bus.req_a[i*nIO +: nIO];
      b_arr[i]  = bus.req_b[i*nIO +: nIO];
      op_arr[i] = bus.req_op[i*3 +: 3];
    end
  end

  // Walk downward so the candidate closest to ptr (smallest offset) wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (bus.req_valid[cand[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  assign grant_fire = (state_q == IDLE) && gnt_vld;
  assign rsp_fire   = (state_q == RESP) && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    busy          = 1'b0;
    case (state_q)
      IDLE: if (rst_n && gnt_vld) bus.req_ready[gnt_idx] = 1'b1;
      EXEC: busy = 1'b1;
      RESP: begin
        busy          = 1'b1;
        bus.rsp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ptr_d      = ptr_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rsp_id_d   = rsp_id_q;
    rsp_z_d    = rsp_z_q;
    rsp_ov_d   = rsp_ov_q;
    op_count_d = op_count_q;
    if (grant_fire) begin
      alu_a_d  = a_arr[gnt_idx];
      alu_b_d  = b_arr[gnt_idx];
      alu_op_d = op_arr[gnt_idx];
      rsp_id_d = gnt_idx;
    end
    if (state_q == EXEC) begin
      rsp_z_d  = alu_z;
      rsp_ov_d = alu_ov;
    end
    if (rsp_fire) begin
      op_count_d = op_count_q + CNTW'(1);
      ptr_d      = (rsp_id_q == IDW'(NREQ - 1)) ? '0 : rsp_id_q + IDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_id_q   <= '0;
      rsp_z_q    <= '0;
      rsp_ov_q   <= 1'b0;
      op_count_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_id_q   <= rsp_id_d;
      rsp_z_q    <= rsp_z_d;
      rsp_ov_q   <= rsp_ov_d;
      op_count_q <= op_count_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign bus.rsp_id = rsp_id_q;
  assign bus.rsp_z  = rsp_z_q;
  assign bus.rsp_ov = rsp_ov_q;
  assign op_count   = op_count_q;

endmodule
